qos_mux_arbiter: RTL and testbench

QOS_MUX_ARBITER -- requirements
Module: qos_mux_arbiter

---
 rtl/qos_mux_arbiter.sv | 114 +++++++++++
 tb/tb_qos_mux_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/qos_mux_arbiter.sv
// Weighted round-robin mux from four class FIFOs into one downstream FIFO.
// Optional macro STRICT_PRIORITY_EN: VC0 preempts WRR without touching ptr/credit.
module qos_mux_arbiter #(
  parameter int unsigned W0 = 4,
  parameter int unsigned W1 = 3,
  parameter int unsigned W2 = 2,
  parameter int unsigned W3 = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  empty_vc,
  input  logic [11:0] data_vc0,
  input  logic [11:0] data_vc1,
  input  logic [11:0] data_vc2,
  input  logic [11:0] data_vc3,
  input  logic        almost_full_out,
  output logic [3:0]  pop,
  output logic        push,
  output logic [11:0] data_out,
  output logic        idle
);

  logic [1:0]  ptr_q, ptr_d;
  logic [2:0]  credit_q, credit_d;
  logic        push_q, push_d;
  logic [11:0] data_q, data_d;

  logic        permit;
  logic        strict_hit;
  logic        grant_vld;
  logic [1:0]  grant_idx;
  logic        found;
  logic [1:0]  cand;
  logic [11:0] grant_data;

  function automatic logic [2:0] weight_of(input logic [1:0] idx);
    logic [2:0] w;
    unique case (idx)
      2'd0:    w = 3'(W0);
      2'd1:    w = 3'(W1);
      2'd2:    w = 3'(W2);
      default: w = 3'(W3);
    endcase
    return w;
  endfunction

  always_comb begin
    ptr_d      = ptr_q;
    credit_d   = credit_q;
    grant_vld  = 1'b0;
    grant_idx  = 2'd0;
    found      = 1'b0;
    cand       = 2'd0;
    permit     = reset && !almost_full_out && (empty_vc != 4'hF);
    strict_hit = 1'b0;
`ifdef STRICT_PRIORITY_EN
    strict_hit = !empty_vc[0];
`endif
    if (permit) begin
      grant_vld = 1'b1;
      if (strict_hit) begin
        grant_idx = 2'd0;
      end else if (!empty_vc[ptr_q] && credit_q != 3'd0) begin
        grant_idx = ptr_q;
        credit_d  = credit_q - 3'd1;
      end else begin
        // Scan ptr+1..ptr+3 then ptr itself, so a lone VC is re-granted without a bubble.
        for (int i = 1; i <= 4; i++) begin
          cand = ptr_q + 2'(i);
          if (!found && !empty_vc[cand]) begin
            found     = 1'b1;
            grant_idx = cand;
          end
        end
        ptr_d    = grant_idx;
        credit_d = weight_of(grant_idx) - 3'd1;
      end
    end
  end

  always_comb begin
    unique case (grant_idx)
      2'd0:    grant_data = data_vc0;
      2'd1:    grant_data = data_vc1;
      2'd2:    grant_data = data_vc2;
      default: grant_data = data_vc3;
    endcase
  end

  always_comb begin
    pop    = grant_vld ? (4'b0001 << grant_idx) : 4'b0000;
    push_d = grant_vld;
    data_d = grant_vld ? grant_data : data_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q    <= 2'd0;
      credit_q <= 3'(W0);
      push_q   <= 1'b0;
      data_q   <= 12'h000;
    end else begin
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      push_q   <= push_d;
      data_q   <= data_d;
    end
  end

  assign push     = push_q;
  assign data_out = data_q;
  assign idle     = (empty_vc == 4'hF) && !push_q;

endmodule

// File: tb/tb_qos_mux_arbiter.sv
// Randomized bench for qos_mux_arbiter against a spec-level WRR model, plus
// directed sequences with literal expectations.
module tb_qos_mux_arbiter;

  localparam int W0 = 4, W1 = 3, W2 = 2, W3 = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  empty_vc = 4'h0;
  logic [11:0] data_vc0 = 12'h011, data_vc1 = 12'h422, data_vc2 = 12'h833, data_vc3 = 12'hC44;
  logic        almost_full_out = 1'b0;
  logic [3:0]  pop;
  logic        push;
  logic [11:0] data_out;
  logic        idle;

  int errors = 0;
  int checks = 0;

  qos_mux_arbiter #(.W0(W0), .W1(W1), .W2(W2), .W3(W3)) dut (
    .clk(clk), .reset(reset), .empty_vc(empty_vc),
    .data_vc0(data_vc0), .data_vc1(data_vc1), .data_vc2(data_vc2), .data_vc3(data_vc3),
    .almost_full_out(almost_full_out), .pop(pop), .push(push),
    .data_out(data_out), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  int          weights [4] = '{W0, W1, W2, W3};
  int          m_ptr, m_credit;
  logic        m_push;
  logic [11:0] m_data;

  initial begin
    int          g;
    bit          keep;
    logic [3:0]  e_s;
    logic        rst_s;
    logic [11:0] d_s [4];
    @(posedge clk);
    m_ptr = 0; m_credit = W0; m_push = 1'b0; m_data = 12'h000;
    forever begin
      @(negedge clk);
      e_s   = empty_vc;
      rst_s = reset;
      d_s   = '{data_vc0, data_vc1, data_vc2, data_vc3};
      g     = -1;
      keep  = 1'b0;
      if (rst_s && !almost_full_out && e_s != 4'hF) begin
`ifdef STRICT_PRIORITY_EN
        if (!e_s[0]) begin g = 0; keep = 1'b1; end
`endif
        if (g < 0 && !e_s[m_ptr] && m_credit > 0) begin
          g = m_ptr;
          m_credit = m_credit - 1;
          keep = 1'b1;
        end
        for (int k = 1; k <= 4 && g < 0; k++)
          if (!e_s[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      end
      chk("pop", 32'(pop), (g < 0) ? 32'd0 : (32'd1 << g));
      chk("push", 32'(push), 32'(m_push));
      chk("data_out", 32'(data_out), 32'(m_data));
      chk("idle", 32'(idle), 32'((e_s == 4'hF) && !m_push));
      @(posedge clk);
      if (!rst_s) begin
        m_ptr = 0; m_credit = W0; m_push = 1'b0; m_data = 12'h000;
      end else begin
        m_push = (g >= 0);
        if (g >= 0) begin
          m_data = d_s[g];
          if (!keep) begin
            m_ptr = g;
            m_credit = weights[g] - 1;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0] seq [10] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8};
    // Two reset cycles with every VC non-empty.
    next_cycle();
    @(negedge clk);
    chk("rst_pop", 32'(pop), 32'h0);
    chk("rst_push", 32'(push), 32'h0);
    chk("rst_data", 32'(data_out), 32'h0);
    next_cycle();
    reset = 1'b1;
`ifndef STRICT_PRIORITY_EN
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("wrr_seq", 32'(pop), 32'(seq[k % 10]));
      if (k >= 1) chk("wrr_push", 32'(push), 32'h1);
      next_cycle();
    end

    // Only VC2 holds data.
    do_reset();
    empty_vc = 4'b1011;
    data_vc2 = 12'h8A5;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("vc2_pop", 32'(pop), 32'h4);
      if (k >= 1) begin
        chk("vc2_push", 32'(push), 32'h1);
        chk("vc2_data", 32'(data_out), 32'h8A5);
      end
      next_cycle();
    end

    // Stall mid VC1 turn with one credit left.
    empty_vc = 4'h0;
    do_reset();
    for (int k = 0; k < 11; k++) begin
      almost_full_out = (k >= 6 && k <= 8);
      @(negedge clk);
      if (k < 4)       chk("af_pop_vc0", 32'(pop), 32'h1);
      else if (k < 6)  chk("af_pop_vc1", 32'(pop), 32'h2);
      else if (k < 9)  chk("af_pop_stall", 32'(pop), 32'h0);
      else if (k == 9) chk("af_pop_resume", 32'(pop), 32'h2);
      else             chk("af_pop_next", 32'(pop), 32'h4);
      if (k == 6) chk("af_inflight_push", 32'(push), 32'h1);
      if (k == 7) chk("af_push_drop", 32'(push), 32'h0);
      next_cycle();
    end
`else
    // VC0 preempts an ongoing VC1 turn, then VC1 finishes its credit.
    do_reset();
    empty_vc = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      empty_vc = (k == 1 || k == 2) ? 4'b0000 : 4'b0001;
      @(negedge clk);
      if (k == 1 || k == 2)  chk("sp_vc0", 32'(pop), 32'h1);
      else if (k < 5)        chk("sp_vc1", 32'(pop), 32'h2);
      else                   chk("sp_vc2", 32'(pop), 32'h4);
      next_cycle();
    end
`endif

    // Randomized traffic, backpressure and occasional resets.
    for (int k = 0; k < 3000; k++) begin
      empty_vc = 4'h0;
      for (int b = 0; b < 4; b++) empty_vc[b] = ($urandom_range(0, 99) < 35);
      if ($urandom_range(0, 19) == 0) empty_vc = 4'hF;
      almost_full_out = ($urandom_range(0, 99) < 15);
      reset = ($urandom_range(0, 99) != 0);
      data_vc0 = {2'd0, 10'($urandom)};
      data_vc1 = {2'd1, 10'($urandom)};
      data_vc2 = {2'd2, 10'($urandom)};
      data_vc3 = {2'd3, 10'($urandom)};
      next_cycle();
    end
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
